// File: rtl/segre_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | segre_pkg : shared sizes and enums for the segre pipeline            |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package segre_pkg;

   localparam int WORD_SIZE = 32;
   localparam int REG_SIZE  = 5;
   localparam int BE_SIZE   = WORD_SIZE / 8;

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10
   } memop_data_type_e;

   typedef enum logic [1:0] {
      IDLE        = 2'b00,
      WAIT_GNT    = 2'b01,
      WAIT_RVALID = 2'b10
   } mem_state_e;

endpackage
`default_nettype wire

// File: rtl/segre_lsu_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | segre_lsu_align : misalign check, store lane steering, load extract  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module segre_lsu_align
   import segre_pkg::*;
(
   input  logic [1:0]           off_i,
   input  memop_data_type_e     type_i,
   input  logic                 sign_ext_i,
   input  logic [WORD_SIZE-1:0] st_data_i,
   input  logic [WORD_SIZE-1:0] rdata_i,
   output logic                 misaligned_o,
   output logic [BE_SIZE-1:0]   be_o,
   output logic [WORD_SIZE-1:0] wdata_o,
   output logic [WORD_SIZE-1:0] ld_data_o
);

   logic [WORD_SIZE-1:0] shifted;

   always_comb begin
      misaligned_o = 1'b0;
      be_o         = '0;
      wdata_o      = '0;
      ld_data_o    = '0;
      shifted      = rdata_i >> {off_i, 3'b000};
      case (type_i)
         BYTE: begin
            be_o      = BE_SIZE'(1) << off_i;
            wdata_o   = {BE_SIZE{st_data_i[7:0]}};
            ld_data_o = {{(WORD_SIZE-8){sign_ext_i & shifted[7]}}, shifted[7:0]};
         end
         HALF: begin
            misaligned_o = off_i[0];
            be_o         = BE_SIZE'(3) << off_i;
            wdata_o      = {(BE_SIZE/2){st_data_i[15:0]}};
            ld_data_o    = {{(WORD_SIZE-16){sign_ext_i & shifted[15]}}, shifted[15:0]};
         end
         WORD: begin
            misaligned_o = |off_i;
            be_o         = '1;
            wdata_o      = st_data_i;
            ld_data_o    = shifted;
         end
         default: misaligned_o = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/segre_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | segre_mem_stage : data-memory access stage, EX/MEM -> MEM/WB         |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module segre_mem_stage
   import segre_pkg::*;
#(
   parameter int unsigned DMEM_TIMEOUT = 0
) (
   input  logic                 clk_i,
   input  logic                 rsn_i,
   input  logic [WORD_SIZE-1:0] alu_res_i,
   input  logic                 rf_we_i,
   input  logic [REG_SIZE-1:0]  rf_waddr_i,
   input  logic [WORD_SIZE-1:0] rf_st_data_i,
   input  memop_data_type_e     memop_type_i,
   input  logic                 memop_rd_i,
   input  logic                 memop_wr_i,
   input  logic                 memop_sign_ext_i,
   input  logic                 tkbr_i,
   input  logic [WORD_SIZE-1:0] new_pc_i,
   output logic                 dmem_req_o,
   output logic                 dmem_we_o,
   output logic [BE_SIZE-1:0]   dmem_be_o,
   output logic [WORD_SIZE-1:0] dmem_addr_o,
   output logic [WORD_SIZE-1:0] dmem_wdata_o,
   input  logic                 dmem_gnt_i,
   input  logic                 dmem_rvalid_i,
   input  logic [WORD_SIZE-1:0] dmem_rdata_i,
   output logic                 stall_o,
   output logic                 rf_we_o,
   output logic [REG_SIZE-1:0]  rf_waddr_o,
   output logic [WORD_SIZE-1:0] rf_wdata_o,
   output logic                 tkbr_o,
   output logic [WORD_SIZE-1:0] new_pc_o,
   output logic                 misaligned_o,
   output logic                 bus_err_o
);

   localparam int CNT_W = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((DMEM_TIMEOUT > 0) ? DMEM_TIMEOUT - 1 : 0);

   mem_state_e           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 run_q;
   logic                 memop, misaligned, aligned_op, in_wait;
   logic                 req, done, timeout, stall;
   logic [BE_SIZE-1:0]   be;
   logic [WORD_SIZE-1:0] wdata, ld_data;

   segre_lsu_align u_align (
      .off_i        (alu_res_i[1:0]),
      .type_i       (memop_type_i),
      .sign_ext_i   (memop_sign_ext_i),
      .st_data_i    (rf_st_data_i),
      .rdata_i      (dmem_rdata_i),
      .misaligned_o (misaligned),
      .be_o         (be),
      .wdata_o      (wdata),
      .ld_data_o    (ld_data)
   );

   // run_q keeps req/stall low while reset is held without feeding rsn_i into logic
   assign memop      = run_q & (memop_rd_i | memop_wr_i);
   assign aligned_op = memop & ~misaligned;
   assign in_wait    = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      req     = 1'b0;
      done    = 1'b0;
      timeout = 1'b0;
      case (state_q)
         IDLE: begin
            req = aligned_op;
            if (aligned_op) begin
               if (!dmem_gnt_i)     state_d = WAIT_GNT;
               else if (memop_rd_i) state_d = WAIT_RVALID;
               else                 done    = 1'b1;
            end
         end
         WAIT_GNT: begin
            req = 1'b1;
            if (dmem_gnt_i) begin
               if (memop_rd_i) begin
                  state_d = WAIT_RVALID;
               end else begin
                  done    = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         WAIT_RVALID: begin
            if (dmem_rvalid_i) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // a response arriving in the final allowed cycle still wins over the abort
      if (DMEM_TIMEOUT != 0 && in_wait && !done && cnt_q == CNT_LAST) begin
         timeout = 1'b1;
         state_d = IDLE;
      end
   end

   assign stall = aligned_op & ~done & ~timeout;
   assign cnt_d = (in_wait && state_d != IDLE) ? cnt_q + CNT_W'(1) : '0;

   assign stall_o      = stall;
   assign dmem_req_o   = req;
   assign dmem_we_o    = req & memop_wr_i;
   assign dmem_be_o    = req ? be : '0;
   assign dmem_addr_o  = {alu_res_i[WORD_SIZE-1:2], 2'b00};
   assign dmem_wdata_o = wdata;

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         run_q        <= 1'b0;
         rf_we_o      <= 1'b0;
         rf_waddr_o   <= '0;
         rf_wdata_o   <= '0;
         tkbr_o       <= 1'b0;
         new_pc_o     <= '0;
         misaligned_o <= 1'b0;
         bus_err_o    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         run_q        <= 1'b1;
         rf_we_o      <= run_q & rf_we_i & ~stall & ~(memop & misaligned) & ~timeout;
         rf_waddr_o   <= rf_waddr_i;
         rf_wdata_o   <= (memop_rd_i & done) ? ld_data : alu_res_i;
         tkbr_o       <= run_q & tkbr_i & ~stall;
         new_pc_o     <= new_pc_i;
         misaligned_o <= memop & misaligned;
         bus_err_o    <= timeout;
      end
   end

endmodule
`default_nettype wire
